dma_chunk_scheduler: RTL and testbench

DMA_CHUNK_SCHEDULER -- requirements
Module: dma_chunk_scheduler

---
 rtl/dma_chunk_scheduler_if.sv | 40 ++++
 rtl/dma_chunk_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_dma_chunk_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_chunk_scheduler_if.sv
// Control/status bundle between a DMA requester and the chunk scheduler.
// Latency: none, wires only; i_/o_ prefixes are taken from the scheduler's point of view.
// Backpressure: none here; the read/write engines pace the scheduler through *_done strobes.
interface dma_chunk_scheduler_if;
   logic        i_start;
   logic        i_abort;
   logic [31:0] i_src_addr;
   logic [31:0] i_dst_addr;
   logic [31:0] i_total_size;
   logic        o_busy;
   logic        o_done;
   logic        o_aborted;
   logic        o_error;
   logic        o_start_read;
   logic [31:0] o_raddr_reg;
   logic [15:0] o_r_size_data;
   logic        i_read_done;
   logic        o_start_write;
   logic [31:0] o_waddr_reg;
   logic [15:0] o_w_size_data;
   logic        i_write_done;

   // Requester plus engine model side
   modport master (
      output i_start, i_abort, i_src_addr, i_dst_addr, i_total_size,
      output i_read_done, i_write_done,
      input  o_busy, o_done, o_aborted, o_error,
      input  o_start_read, o_raddr_reg, o_r_size_data,
      input  o_start_write, o_waddr_reg, o_w_size_data
   );

   // Scheduler side
   modport slave (
      input  i_start, i_abort, i_src_addr, i_dst_addr, i_total_size,
      input  i_read_done, i_write_done,
      output o_busy, o_done, o_aborted, o_error,
      output o_start_read, o_raddr_reg, o_r_size_data,
      output o_start_write, o_waddr_reg, o_w_size_data
   );
endinterface

// File: rtl/dma_chunk_scheduler.sv
// Splits a DMA transfer into read/write chunk pairs of at most CHUNK_BYTES; optional wait watchdog under DMA_SCHED_TIMEOUT_EN.
// Latency: start_read one cycle after an accepted start; done one cycle after FIN (two cycles for a zero-size start).
// Backpressure: waits indefinitely on read_done/write_done unless the watchdog macro is defined; start while busy is dropped.
module dma_chunk_scheduler #(
   parameter int CHUNK_BYTES    = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic               clk,
   input logic               rst,
   dma_chunk_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_ISSUE,
      ST_WR_WAIT,
      ST_FIN
   } state_t;

   localparam logic [31:0] LP_CHUNK = 32'(CHUNK_BYTES);

   // Reject configurations that cannot be represented on the 16-bit size buses.
   generate
      if ((CHUNK_BYTES % 4) != 0 || CHUNK_BYTES < 4 || CHUNK_BYTES > 65532 || TIMEOUT_CYCLES < 1) begin : g_bad_param
         $error("dma_chunk_scheduler: illegal CHUNK_BYTES or TIMEOUT_CYCLES");
      end
   endgenerate

   state_t      r_state;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_rem;
   logic [31:0] r_chunk;
   logic        r_abort_lat;
   logic        r_busy;
   logic        r_done;
   logic        r_aborted;
   logic        r_start_read;
   logic        r_start_write;
   logic [31:0] r_raddr;
   logic [31:0] r_waddr;
   logic [15:0] r_rsize;
   logic [15:0] r_wsize;

   logic [31:0] w_chunk_first;
   logic [31:0] w_rem_next;
   logic [31:0] w_chunk_next;
   logic        w_stop_after_wr;

   // First chunk comes straight from the requested size; later chunks from what is left.
   assign w_chunk_first   = (bus.i_total_size > LP_CHUNK) ? LP_CHUNK : bus.i_total_size;
   assign w_rem_next      = r_rem - r_chunk;
   assign w_chunk_next    = (w_rem_next > LP_CHUNK) ? LP_CHUNK : w_rem_next;
   // An abort arriving on the same cycle as write_done still ends the transfer here.
   assign w_stop_after_wr = (w_rem_next == 32'd0) || r_abort_lat || bus.i_abort;

`ifdef DMA_SCHED_TIMEOUT_EN
   localparam logic [31:0] LP_WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_wdog;
   logic        r_error;
   logic        w_wdog_expired;
   assign w_wdog_expired = (r_wdog == LP_WDOG_LAST);
   assign bus.o_error    = r_error;
`else
   assign bus.o_error    = 1'b0;
`endif

   assign bus.o_busy        = r_busy;
   assign bus.o_done        = r_done;
   assign bus.o_aborted     = r_aborted;
   assign bus.o_start_read  = r_start_read;
   assign bus.o_raddr_reg   = r_raddr;
   assign bus.o_r_size_data = r_rsize;
   assign bus.o_start_write = r_start_write;
   assign bus.o_waddr_reg   = r_waddr;
   assign bus.o_w_size_data = r_wsize;

   // Transfer FSM: all status and engine-control outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_src         <= 32'd0;
         r_dst         <= 32'd0;
         r_rem         <= 32'd0;
         r_chunk       <= 32'd0;
         r_abort_lat   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_start_read  <= 1'b0;
         r_start_write <= 1'b0;
         r_raddr       <= 32'd0;
         r_waddr       <= 32'd0;
         r_rsize       <= 16'd0;
         r_wsize       <= 16'd0;
`ifdef DMA_SCHED_TIMEOUT_EN
         r_wdog        <= 32'd0;
         r_error       <= 1'b0;
`endif
      end else begin
         r_done        <= 1'b0;
         r_start_read  <= 1'b0;
         r_start_write <= 1'b0;

         if (r_state != ST_IDLE && bus.i_abort) begin
            r_abort_lat <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_src       <= bus.i_src_addr;
                  r_dst       <= bus.i_dst_addr;
                  r_rem       <= bus.i_total_size;
                  r_chunk     <= w_chunk_first;
                  r_abort_lat <= 1'b0;
                  r_aborted   <= 1'b0;
                  r_busy      <= 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                  r_error     <= 1'b0;
`endif
                  // A zero-byte request completes without touching either engine.
                  r_state     <= (bus.i_total_size == 32'd0) ? ST_FIN : ST_RD_ISSUE;
               end
            end

            ST_RD_ISSUE: begin
               r_start_read <= 1'b1;
               r_raddr      <= r_src;
               r_rsize      <= r_chunk[15:0];
`ifdef DMA_SCHED_TIMEOUT_EN
               r_wdog       <= 32'd0;
`endif
               r_state      <= ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
               if (bus.i_read_done) begin
                  r_state <= ST_WR_ISSUE;
               end
`ifdef DMA_SCHED_TIMEOUT_EN
               else if (w_wdog_expired) begin
                  r_error <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_wdog  <= r_wdog + 32'd1;
               end
`endif
            end

            ST_WR_ISSUE: begin
               r_start_write <= 1'b1;
               r_waddr       <= r_dst;
               r_wsize       <= r_chunk[15:0];
`ifdef DMA_SCHED_TIMEOUT_EN
               r_wdog        <= 32'd0;
`endif
               r_state       <= ST_WR_WAIT;
            end

            ST_WR_WAIT: begin
               if (bus.i_write_done) begin
                  // Addresses wrap silently at 2^32.
                  r_rem   <= w_rem_next;
                  r_src   <= r_src + r_chunk;
                  r_dst   <= r_dst + r_chunk;
                  r_chunk <= w_chunk_next;
                  r_state <= w_stop_after_wr ? ST_FIN : ST_RD_ISSUE;
               end
`ifdef DMA_SCHED_TIMEOUT_EN
               else if (w_wdog_expired) begin
                  r_error <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_wdog  <= r_wdog + 32'd1;
               end
`endif
            end

            ST_FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               if (r_abort_lat) begin
                  r_aborted <= 1'b1;
               end
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_chunk_scheduler.sv
// Randomized bench for dma_chunk_scheduler against a chunk-list reference model.
// Latency: checks zero-size done latency and, with DMA_SCHED_TIMEOUT_EN, the watchdog window.
// Backpressure: engine responses use random delays; spurious done/start/abort pulses must be ignored.
module tb_dma_chunk_scheduler;

   localparam int CB = 64;
`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dma_chunk_scheduler_if bus();

   dma_chunk_scheduler #(
      .CHUNK_BYTES    (CB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Last values the engine-control outputs should be holding.
   logic [31:0] m_raddr, m_waddr, m_rsize, m_wsize;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_start      = 1'b0;
      bus.i_abort      = 1'b0;
      bus.i_read_done  = 1'b0;
      bus.i_write_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_busy"},  32'(bus.o_busy), 0);
      chk({pfx, "_done"},  32'(bus.o_done), 0);
      chk({pfx, "_srd"},   32'(bus.o_start_read), 0);
      chk({pfx, "_swr"},   32'(bus.o_start_write), 0);
      chk({pfx, "_raddr"}, bus.o_raddr_reg, 0);
      chk({pfx, "_waddr"}, bus.o_waddr_reg, 0);
      chk({pfx, "_rsize"}, 32'(bus.o_r_size_data), 0);
      chk({pfx, "_wsize"}, 32'(bus.o_w_size_data), 0);
      chk({pfx, "_abt"},   32'(bus.o_aborted), 0);
      chk({pfx, "_err"},   32'(bus.o_error), 0);
   endtask

   // abort_k > 0: pulse abort while the abort_k-th read is outstanding.
   // rst_on_wr: reset while the first write is outstanding. hang: never answer the read.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size,
                           input int abort_k, input bit spur, input bit rst_on_wr, input bit hang);
      logic [31:0] q_src[$];
      logic [31:0] q_dst[$];
      logic [31:0] q_sz[$];
      logic [31:0] rem, s, d, c;
      int  nchunks, exp_nrd, exp_nwr, nrd, nwr, rd_cnt, wr_cnt, t_start, t_rdwait;
      bit  exp_abt, rd_pend, wr_pend, abort_sent, seen_done, stop;

      rem = size; s = src; d = dst;
      while (rem != 0) begin
         c = (rem < 32'(CB)) ? rem : 32'(CB);
         q_src.push_back(s);
         q_dst.push_back(d);
         q_sz.push_back(c);
         rem = rem - c; s = s + c; d = d + c;
      end
      nchunks = q_sz.size();
      exp_abt = (abort_k > 0) && (abort_k <= nchunks) && !hang;
      if (hang) begin
         exp_nrd = (nchunks > 0) ? 1 : 0;
         exp_nwr = 0;
      end else if (exp_abt) begin
         exp_nrd = abort_k;
         exp_nwr = abort_k;
      end else begin
         exp_nrd = nchunks;
         exp_nwr = nchunks;
      end

      nrd = 0; nwr = 0; rd_cnt = -1; wr_cnt = -1; t_rdwait = 0;
      rd_pend = 0; wr_pend = 0; abort_sent = 0; seen_done = 0; stop = 0;

      @(negedge clk);
      drive_idle();
      bus.i_src_addr   = src;
      bus.i_dst_addr   = dst;
      bus.i_total_size = size;
      bus.i_start      = 1'b1;
      t_start          = cyc;

      for (int k = 0; k < 800 && !stop; k++) begin
         @(negedge clk);
         if (bus.o_start_read) begin
            if (nrd < exp_nrd) begin
               chk("rd_addr", bus.o_raddr_reg, q_src[nrd]);
               chk("rd_size", 32'(bus.o_r_size_data), q_sz[nrd]);
               m_raddr = q_src[nrd];
               m_rsize = q_sz[nrd];
            end else begin
               chk("rd_extra", 32'(nrd + 1), 32'(exp_nrd));
            end
            nrd++;
            rd_pend  = 1;
            rd_cnt   = hang ? -1 : int'($urandom_range(0, 3));
            t_rdwait = cyc;
         end
         if (bus.o_start_write) begin
            if (nwr < exp_nwr) begin
               chk("wr_addr", bus.o_waddr_reg, q_dst[nwr]);
               chk("wr_size", 32'(bus.o_w_size_data), q_sz[nwr]);
               m_waddr = q_dst[nwr];
               m_wsize = q_sz[nwr];
            end else begin
               chk("wr_extra", 32'(nwr + 1), 32'(exp_nwr));
            end
            nwr++;
            wr_pend = 1;
            wr_cnt  = int'($urandom_range(0, 3));
            if (rst_on_wr) begin
               drive_idle();
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               chk_all_zero("rst_mid");
               m_raddr = 0; m_waddr = 0; m_rsize = 0; m_wsize = 0;
               for (int j = 0; j < 6; j++) begin
                  @(negedge clk);
                  chk("rst_nodone", 32'(bus.o_done), 0);
                  chk("rst_idle", 32'(bus.o_busy), 0);
               end
               return;
            end
         end
         if (bus.o_done) begin
            seen_done = 1;
            stop      = 1;
         end

         drive_idle();
         if (!stop) begin
            if (rd_pend) begin
               if (rd_cnt == 0) begin
                  bus.i_read_done = 1'b1;
                  rd_pend = 0;
                  rd_cnt  = -1;
               end else if (rd_cnt > 0) begin
                  rd_cnt--;
               end
               if (abort_k > 0 && !abort_sent && nrd == abort_k) begin
                  bus.i_abort = 1'b1;
                  abort_sent  = 1;
               end
            end else if (spur && $urandom_range(0, 3) == 0) begin
               bus.i_read_done = 1'b1;
            end
            if (wr_pend) begin
               if (wr_cnt == 0) begin
                  bus.i_write_done = 1'b1;
                  wr_pend = 0;
                  wr_cnt  = -1;
               end else begin
                  wr_cnt--;
               end
            end else if (spur && $urandom_range(0, 3) == 0) begin
               bus.i_write_done = 1'b1;
            end
            if (spur && $urandom_range(0, 5) == 0) begin
               bus.i_start      = 1'b1;
               bus.i_total_size = $urandom;
               bus.i_src_addr   = $urandom;
            end
         end
      end

      chk("done_seen", 32'(seen_done), 1);
      if (seen_done) begin
         chk("n_reads",  32'(nrd), 32'(exp_nrd));
         chk("n_writes", 32'(nwr), 32'(exp_nwr));
         chk("busy_end", 32'(bus.o_busy), 0);
         chk("aborted",  32'(bus.o_aborted), 32'(exp_abt));
         chk("error",    32'(bus.o_error), 32'(hang));
         chk("hold_raddr", bus.o_raddr_reg, m_raddr);
         chk("hold_waddr", bus.o_waddr_reg, m_waddr);
         chk("hold_rsize", 32'(bus.o_r_size_data), m_rsize);
         chk("hold_wsize", 32'(bus.o_w_size_data), m_wsize);
         if (size == 0) begin
            chk("zero_lat", 32'(cyc - t_start), 2);
         end
         if (hang) begin
            chk("to_window", 32'((cyc - t_rdwait) >= 16 && (cyc - t_rdwait) <= 17), 1);
         end
         @(negedge clk);
         chk("done_pulse", 32'(bus.o_done), 0);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rs, rd, rz;
      int          ak, nch;

      rst = 1'b1;
      drive_idle();
      bus.i_src_addr   = 0;
      bus.i_dst_addr   = 0;
      bus.i_total_size = 0;
      m_raddr = 0; m_waddr = 0; m_rsize = 0; m_wsize = 0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      run_xfer(32'h0000_0100, 32'h0000_0004, 14,  0, 0, 0, 0);
      run_xfer(32'h0000_1000, 32'h0000_2000, 150, 0, 0, 0, 0);
      run_xfer(32'h0000_1000, 32'h0000_2000, 150, 1, 0, 0, 0);
      run_xfer(32'h0000_0055, 32'h0000_0077, 0,   0, 1, 0, 0);
      run_xfer(32'h0000_00A0, 32'h0000_00B0, 150, 0, 1, 1, 0);
      run_xfer(32'h0000_0010, 32'h0000_0020, 8,   0, 0, 0, 0);
      run_xfer(32'hFFFF_FFE0, 32'hFFFF_FFF0, 100, 0, 1, 0, 0);

      // abort while idle must not leak into the next transfer
      @(negedge clk);
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      run_xfer(32'h0000_0300, 32'h0000_0400, 128, 0, 0, 0, 0);

`ifdef DMA_SCHED_TIMEOUT_EN
      run_xfer(32'h0000_0500, 32'h0000_0600, 40, 0, 0, 0, 1);
      run_xfer(32'h0000_0700, 32'h0000_0800, 8,  0, 0, 0, 0);
`endif

      for (int t = 0; t < 40; t++) begin
         rs = $urandom;
         rd = $urandom;
         case ($urandom_range(0, 4))
            0:       rz = 0;
            1:       rz = 32'(CB) * $urandom_range(1, 4);
            default: rz = $urandom_range(1, 300);
         endcase
         nch = int'((rz + 32'(CB) - 1) / 32'(CB));
         ak  = (nch > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nch)) : 0;
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.i_abort = 1'b1;
            @(negedge clk);
            bus.i_abort = 1'b0;
         end
         run_xfer(rs, rd, rz, ak, 1, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
